// File: rtl/ysyx_22050535_lsu.sv
// Load/store unit: one request at a time, alignment check, fixed-latency memory access,
// byte/half/word store shaping and load extraction, response held until accepted.
module ysyx_22050535_lsu #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              wen_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;

  logic              req_err;
  logic              accept;
  logic              last;
  logic [1:0]        off;
  logic [31:0]       sh;
  logic [31:0]       load_ext;
  logic [3:0]        wmask_shaped;
  logic [31:0]       wdata_shaped;
  logic [7:0]        lane_data [4];

  assign req_err = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && (req_addr[1:0] != 2'b00));
  assign accept  = (state_reg == IDLE) && req_valid;
  assign last    = (cnt_reg == '0);
  assign off     = addr_reg[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  if (last) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured request, access counter and response payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      wen_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      size_reg  <= '0;
      uns_reg   <= 1'b0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      cnt_reg   <= CNT_LOAD;
      wen_reg   <= req_wen;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      size_reg  <= req_size;
      uns_reg   <= req_unsigned;
      rdata_reg <= '0;
      err_reg   <= req_err;
    end else if (state_reg == ACCESS) begin
      if (last) rdata_reg <= wen_reg ? 32'd0 : load_ext;
      else      cnt_reg   <= cnt_reg - CNT_ONE;
    end
  end

  // Load extraction: shift the addressed lane down, then sign/zero extend
  assign sh = mem_rdata >> {off, 3'b000};
  always_comb begin
    case (size_reg)
      2'd0:    load_ext = {{24{~uns_reg & sh[7]}}, sh[7:0]};
      2'd1:    load_ext = {{16{~uns_reg & sh[15]}}, sh[15:0]};
      default: load_ext = sh;
    endcase
  end

  // Store shaping: each byte lane carries the data byte it would hold after replication
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_data[gi] = (size_reg == 2'd0) ? wdata_reg[7:0] :
                           (size_reg == 2'd1) ? wdata_reg[8*(gi%2) +: 8] :
                                                wdata_reg[8*gi +: 8];
    assign wdata_shaped[8*gi +: 8] = lane_data[gi];
  end

  always_comb begin
    case (size_reg)
      2'd0:    wmask_shaped = 4'b0001 << off;
      2'd1:    wmask_shaped = 4'b0011 << off;
      default: wmask_shaped = 4'b1111;
    endcase
  end

  // Outputs decoded from state so reset drops them immediately
  always_comb begin
    req_ready  = (state_reg == IDLE);
    mem_valid  = (state_reg == ACCESS);
    mem_wen    = (state_reg == ACCESS) && wen_reg && last;
    mem_addr   = (state_reg == ACCESS) ? {addr_reg[31:2], 2'b00} : 32'd0;
    mem_wdata  = (state_reg == ACCESS) ? wdata_shaped : 32'd0;
    mem_wmask  = mem_wen ? wmask_shaped : 4'b0000;
    resp_valid = (state_reg == RESP);
    resp_rdata = (state_reg == RESP) ? rdata_reg : 32'd0;
    resp_err   = (state_reg == RESP) && err_reg;
  end

endmodule

// File: tb/tb_ysyx_22050535_lsu.sv
// Bench for the LSU: two instances (LATENCY 1 and 3) on a shared word memory,
// directed scenarios followed by random transactions checked against a byte-level model.
module tb_ysyx_22050535_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;

  logic        rv1 = 1'b0, rv3 = 1'b0, rsr1 = 1'b0, rsr3 = 1'b0;
  logic        rr1, rr3, mv1, mv3, mw1, mw3, rsv1, rsv3, re1, re3;
  logic [31:0] ma1, ma3, mwd1, mwd3, mrd1, mrd3, rd1, rd3;
  logic [3:0]  mm1, mm3;

  logic [31:0] mem [16];
  assign mrd1 = mem[ma1[5:2]];
  assign mrd3 = mem[ma3[5:2]];

  always #5 clk = ~clk;

  ysyx_22050535_lsu #(.LATENCY(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_valid(mv1), .mem_wen(mw1), .mem_addr(ma1), .mem_wdata(mwd1), .mem_wmask(mm1),
    .mem_rdata(mrd1), .resp_valid(rsv1), .resp_ready(rsr1), .resp_rdata(rd1), .resp_err(re1));

  ysyx_22050535_lsu #(.LATENCY(3), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rr3), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_valid(mv3), .mem_wen(mw3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_wmask(mm3),
    .mem_rdata(mrd3), .resp_valid(rsv3), .resp_ready(rsr3), .resp_rdata(rd3), .resp_err(re3));

  // Selected instance view
  logic sel = 1'b0;
  logic        rr_s, mv_s, mw_s, rsv_s, re_s;
  logic [31:0] ma_s, mwd_s, rd_s;
  logic [3:0]  mm_s;
  assign rr_s  = sel ? rr3  : rr1;
  assign mv_s  = sel ? mv3  : mv1;
  assign mw_s  = sel ? mw3  : mw1;
  assign rsv_s = sel ? rsv3 : rsv1;
  assign re_s  = sel ? re3  : re1;
  assign ma_s  = sel ? ma3  : ma1;
  assign mwd_s = sel ? mwd3 : mwd1;
  assign rd_s  = sel ? rd3  : rd1;
  assign mm_s  = sel ? mm3  : mm1;

  int wen_total3 = 0;
  always @(posedge clk) if (mw3) wen_total3 <= wen_total3 + 1;

  int errors = 0;
  int checks = 0;
  int txn = 0;
  logic [31:0] last_rd, last_wd;
  logic [3:0]  last_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input bit u, input int stall);
    int L, n, off, cyc, nvalid, nwen, wen_cyc;
    bit exp_err;
    logic [31:0] word, v, m, exp_rd, exp_wd, got_wd;
    logic [3:0] exp_mask, got_mask;
    L = s ? 3 : 1;
    n = 1 << sz;
    off = int'(a[1:0]);
    exp_err = (sz == 2'd3) || ((off % n) != 0);
    word = mem[a[5:2]];
    exp_rd = 32'd0;
    if (!w && !exp_err) begin
      v = word >> (8 * off);
      if (n < 4) begin
        m = (32'd1 << (8 * n)) - 32'd1;
        v = v & m;
        if (!u && v[8*n-1]) v = v | ~m;
      end
      exp_rd = v;
    end
    exp_mask = '0;
    exp_wd = '0;
    for (int b = 0; b < 4; b++) begin
      exp_mask[b] = (b >= off) && (b < off + n);
      exp_wd[8*b +: 8] = 8'(d >> (8 * (b % n)));
    end

    sel = s;
    @(negedge clk);
    req_wen = w; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
    if (s) rv3 = 1'b1; else rv1 = 1'b1;
    chk("req_ready_idle", {31'd0, rr_s}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rv1 = 1'b0; rv3 = 1'b0;
    req_wen = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);

    cyc = 1; nvalid = 0; nwen = 0; wen_cyc = 0; got_mask = '0; got_wd = '0;
    while (!rsv_s && cyc <= 40) begin
      if (mv_s) begin
        nvalid++;
        chk("mem_addr", ma_s, {a[31:2], 2'b00});
      end
      if (mw_s) begin
        nwen++;
        wen_cyc = cyc;
        got_mask = mm_s;
        got_wd = mwd_s;
        for (int b = 0; b < 4; b++)
          if (mm_s[b]) mem[ma_s[5:2]][8*b +: 8] = mwd_s[8*b +: 8];
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), exp_err ? 32'd1 : 32'(L + 1));
    chk("mem_valid_cycles", 32'(nvalid), exp_err ? 32'd0 : 32'(L));
    chk("wen_pulses", 32'(nwen), (w && !exp_err) ? 32'd1 : 32'd0);
    if (w && !exp_err) begin
      chk("wen_cycle", 32'(wen_cyc), 32'(L));
      chk("wmask", {28'd0, got_mask}, {28'd0, exp_mask});
      chk("wdata", got_wd, exp_wd);
    end
    last_mask = got_mask;
    last_wd = got_wd;

    for (int i = 0; i < stall; i++) begin
      chk("resp_valid_hold", {31'd0, rsv_s}, 32'd1);
      chk("resp_rdata_hold", rd_s, exp_rd);
      chk("req_ready_busy", {31'd0, rr_s}, 32'd0);
      @(negedge clk);
    end
    chk("resp_valid", {31'd0, rsv_s}, 32'd1);
    chk("resp_rdata", rd_s, exp_rd);
    chk("resp_err", {31'd0, re_s}, {31'd0, exp_err});
    last_rd = rd_s;
    if (s) rsr3 = 1'b1; else rsr1 = 1'b1;
    @(negedge clk);
    rsr1 = 1'b0; rsr3 = 1'b0;
    chk("resp_valid_drop", {31'd0, rsv_s}, 32'd0);
    chk("req_ready_back", {31'd0, rr_s}, 32'd1);
    txn++;
    $display("txn %0d: lat=%0d wen=%0d addr=%h size=%0d uns=%0d wdata=%h rdata=%h err=%0d",
             txn, L, w, a, sz, u, d, last_rd, exp_err);
  endtask

  initial begin
    logic [31:0] old_word;
    int wen_before;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    // Reset state of both instances
    #2;
    chk("rst_req_ready1", {31'd0, rr1}, 32'd1);
    chk("rst_req_ready3", {31'd0, rr3}, 32'd1);
    chk("rst_mem_valid", {30'd0, mv1, mv3}, 32'd0);
    chk("rst_mem_wen", {30'd0, mw1, mw3}, 32'd0);
    chk("rst_mem_addr", ma1 | ma3, 32'd0);
    chk("rst_mem_wdata", mwd1 | mwd3, 32'd0);
    chk("rst_mem_wmask", {28'd0, mm1 | mm3}, 32'd0);
    chk("rst_resp", {28'd0, rsv1, rsv3, re1, re3}, 32'd0);
    chk("rst_resp_rdata", rd1 | rd3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    mem[1] = 32'hDEADBEEF;
    run(0, 0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 0);
    chk("tp_load_word", last_rd, 32'hDEADBEEF);
    mem[0] = 32'h85FF_0000;
    run(0, 0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 0);
    chk("tp_load_byte_s", last_rd, 32'hFFFF_FF85);
    run(0, 0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 0);
    chk("tp_load_byte_u", last_rd, 32'h0000_0085);
    run(0, 1, 32'h8000_0002, 32'h1234_ABCD, 2'd1, 1'b0, 0);
    chk("tp_store_mask", {28'd0, last_mask}, 32'h0000_000C);
    chk("tp_store_wdata", last_wd, 32'hABCD_ABCD);
    chk("tp_store_rdata", last_rd, 32'd0);
    run(0, 0, 32'h8000_0006, 32'h0, 2'd2, 1'b0, 0);
    run(0, 0, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 0);
    run(1, 1, 32'h8000_000C, 32'h5566_7788, 2'd2, 1'b0, 5);
    run(1, 0, 32'h8000_000E, 32'h0, 2'd1, 1'b0, 5);

    // Reset pulse in the middle of a LATENCY=3 store
    old_word = mem[2];
    wen_before = wen_total3;
    sel = 1'b1;
    @(negedge clk);
    req_wen = 1'b1; req_addr = 32'h8000_0008; req_wdata = ~old_word; req_size = 2'd2;
    rv3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv3 = 1'b0;
    chk("rst_mid_busy", {31'd0, mv3}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_valid", {30'd0, mv3, mw3}, 32'd0);
    chk("rst_mid_outputs", ma3 | mwd3 | rd3 | {28'd0, mm3}, 32'd0);
    chk("rst_mid_resp", {30'd0, rsv3, re3}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, rr3}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_write", 32'(wen_total3 - wen_before), 32'd0);
    chk("rst_mid_ready_after", {31'd0, rr3}, 32'd1);
    chk("rst_mid_no_resp", {31'd0, rsv3}, 32'd0);

    // Random transactions on both instances
    for (int i = 0; i < 40; i++)
      run(1'($urandom), 1'($urandom), 32'h8000_0000 | ($urandom % 64), $urandom,
          2'($urandom), 1'($urandom), int'($urandom % 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
